// File: rtl/cla_result_checker.sv
// Receive-side checker for the carry-lookahead adder: recomputes a+b+cin, counts passes/fails.
// Optional first-failure capture is enabled by defining CHK_FIRST_FAIL_EN.
module cla_result_checker #(
  parameter int WIDTH       = 4,
  parameter int COUNT_W     = 16,
  parameter int NUM_VECTORS = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               vec_valid,
  output logic               vec_ready,
  input  logic [WIDTH-1:0]   vec_a,
  input  logic [WIDTH-1:0]   vec_b,
  input  logic               vec_cin,
  input  logic [WIDTH-1:0]   vec_sum,
  input  logic               vec_cout,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [COUNT_W-1:0] vec_cnt,
  output logic [COUNT_W-1:0] pass_cnt,
  output logic [COUNT_W-1:0] fail_cnt
`ifdef CHK_FIRST_FAIL_EN
  ,
  output logic               ff_valid,
  output logic [COUNT_W-1:0] ff_index,
  output logic [WIDTH-1:0]   ff_a,
  output logic [WIDTH-1:0]   ff_b,
  output logic [WIDTH-1:0]   ff_sum,
  output logic               ff_cin,
  output logic               ff_cout,
  output logic [WIDTH:0]     ff_exp
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [COUNT_W-1:0] NUM_V   = COUNT_W'(NUM_VECTORS);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t             state_reg;
  logic [COUNT_W-1:0] vec_cnt_reg, pass_cnt_reg, fail_cnt_reg;
  logic               error_reg;

  logic               cap_valid_reg;
  logic [WIDTH-1:0]   cap_a_reg, cap_b_reg, cap_sum_reg;
  logic               cap_cin_reg, cap_cout_reg;

  logic [WIDTH:0]     expected;
  logic               match;
  logic               xfer;

  assign vec_ready = (state_reg == RUN) && (vec_cnt_reg < NUM_V);
  assign xfer      = vec_valid && vec_ready;
  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign error     = error_reg;
  assign vec_cnt   = vec_cnt_reg;
  assign pass_cnt  = pass_cnt_reg;
  assign fail_cnt  = fail_cnt_reg;

  // Golden result is evaluated one cycle after capture, at full WIDTH+1 precision.
  assign expected = {1'b0, cap_a_reg} + {1'b0, cap_b_reg} + {{WIDTH{1'b0}}, cap_cin_reg};
  assign match    = ({cap_cout_reg, cap_sum_reg} == expected);

`ifdef CHK_FIRST_FAIL_EN
  logic               ff_valid_reg, ff_cin_reg, ff_cout_reg;
  logic [COUNT_W-1:0] ff_index_reg, cap_idx_reg;
  logic [WIDTH-1:0]   ff_a_reg, ff_b_reg, ff_sum_reg;
  logic [WIDTH:0]     ff_exp_reg;

  assign ff_valid = ff_valid_reg;
  assign ff_index = ff_index_reg;
  assign ff_a     = ff_a_reg;
  assign ff_b     = ff_b_reg;
  assign ff_sum   = ff_sum_reg;
  assign ff_cin   = ff_cin_reg;
  assign ff_cout  = ff_cout_reg;
  assign ff_exp   = ff_exp_reg;

  always_ff @(posedge clk) begin
    if (rst || (start && state_reg != RUN)) begin
      ff_valid_reg <= 1'b0;
      ff_index_reg <= '0;
      ff_a_reg     <= '0;
      ff_b_reg     <= '0;
      ff_sum_reg   <= '0;
      ff_cin_reg   <= 1'b0;
      ff_cout_reg  <= 1'b0;
      ff_exp_reg   <= '0;
      cap_idx_reg  <= '0;
    end else if (state_reg == RUN) begin
      if (xfer) cap_idx_reg <= vec_cnt_reg;
      if (cap_valid_reg && !match && !ff_valid_reg) begin
        ff_valid_reg <= 1'b1;
        ff_index_reg <= cap_idx_reg;
        ff_a_reg     <= cap_a_reg;
        ff_b_reg     <= cap_b_reg;
        ff_sum_reg   <= cap_sum_reg;
        ff_cin_reg   <= cap_cin_reg;
        ff_cout_reg  <= cap_cout_reg;
        ff_exp_reg   <= expected;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      vec_cnt_reg   <= '0;
      pass_cnt_reg  <= '0;
      fail_cnt_reg  <= '0;
      error_reg     <= 1'b0;
      cap_valid_reg <= 1'b0;
      cap_a_reg     <= '0;
      cap_b_reg     <= '0;
      cap_sum_reg   <= '0;
      cap_cin_reg   <= 1'b0;
      cap_cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg     <= RUN;
            vec_cnt_reg   <= '0;
            pass_cnt_reg  <= '0;
            fail_cnt_reg  <= '0;
            error_reg     <= 1'b0;
            cap_valid_reg <= 1'b0;
          end
        end
        RUN: begin
          cap_valid_reg <= xfer;
          if (xfer) begin
            cap_a_reg    <= vec_a;
            cap_b_reg    <= vec_b;
            cap_cin_reg  <= vec_cin;
            cap_sum_reg  <= vec_sum;
            cap_cout_reg <= vec_cout;
            if (vec_cnt_reg != CNT_MAX) vec_cnt_reg <= vec_cnt_reg + 1'b1;
          end
          if (cap_valid_reg) begin
            if (match) begin
              if (pass_cnt_reg != CNT_MAX) pass_cnt_reg <= pass_cnt_reg + 1'b1;
            end else begin
              if (fail_cnt_reg != CNT_MAX) fail_cnt_reg <= fail_cnt_reg + 1'b1;
              error_reg <= 1'b1;
            end
          end
          // Leave RUN only once the last captured vector has been scored.
          if (vec_cnt_reg == NUM_V && !cap_valid_reg) state_reg <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_result_checker.sv
// Directed bench for cla_result_checker: cycle-level reference model plus literal spot checks.
module tb_cla_result_checker;
  localparam int WIDTH = 4;
  localparam int CW    = 16;
  localparam int N     = 512;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, vec_valid = 1'b0;
  logic vec_ready, busy, done, error;
  logic [WIDTH-1:0] vec_a = '0, vec_b = '0, vec_sum = '0;
  logic vec_cin = 1'b0, vec_cout = 1'b0;
  logic [CW-1:0] vec_cnt, pass_cnt, fail_cnt;
`ifdef CHK_FIRST_FAIL_EN
  logic ff_valid, ff_cin, ff_cout;
  logic [CW-1:0] ff_index;
  logic [WIDTH-1:0] ff_a, ff_b, ff_sum;
  logic [WIDTH:0] ff_exp;
`endif

  cla_result_checker #(.WIDTH(WIDTH), .COUNT_W(CW), .NUM_VECTORS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_a(vec_a), .vec_b(vec_b), .vec_cin(vec_cin), .vec_sum(vec_sum), .vec_cout(vec_cout),
    .busy(busy), .done(done), .error(error),
    .vec_cnt(vec_cnt), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`ifdef CHK_FIRST_FAIL_EN
    , .ff_valid(ff_valid), .ff_index(ff_index), .ff_a(ff_a), .ff_b(ff_b), .ff_sum(ff_sum),
    .ff_cin(ff_cin), .ff_cout(ff_cout), .ff_exp(ff_exp)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: 0=idle, 1=run, 2=done; results scored one edge after transfer.
  int m_state = 0, m_vec = 0, m_pass = 0, m_fail = 0;
  bit m_err = 0, live = 0;
  bit pend[$];

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_state = 0; m_vec = 0; m_pass = 0; m_fail = 0; m_err = 0;
        pend.delete();
        live = 1;
      end else begin
        automatic bit xf  = (m_state == 1) && (m_vec < N) && vec_valid;
        automatic bit fin = (m_state == 1) && (m_vec == N) && (pend.size() == 0);
        if (pend.size() > 0) begin
          if (pend.pop_front()) m_pass++;
          else begin m_fail++; m_err = 1; end
        end
        if (start && m_state != 1) begin
          m_state = 1; m_vec = 0; m_pass = 0; m_fail = 0; m_err = 0;
          pend.delete();
        end else if (xf) begin
          pend.push_back((int'(vec_cout) * 16 + int'(vec_sum)) ==
                         (int'(vec_a) + int'(vec_b) + int'(vec_cin)));
          m_vec++;
        end else if (fin) begin
          m_state = 2;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        chk("ready", vec_ready, (m_state == 1) && (m_vec < N));
        chk("busy", busy, m_state == 1);
        chk("done", done, m_state == 2);
        chk("error", error, m_err);
        chk("vec_cnt", vec_cnt, m_vec);
        chk("pass_cnt", pass_cnt, m_pass);
        chk("fail_cnt", fail_cnt, m_fail);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic put_vec(input int i, input bit fault);
    int s;
    vec_a   = i[8:5];
    vec_b   = i[4:1];
    vec_cin = i[0];
    s       = int'(vec_a) + int'(vec_b) + int'(vec_cin);
    vec_sum = s[3:0];
    if (fault) vec_sum[0] = 1'b0;
    vec_cout = s[4];
  endtask

  task automatic sweep(input bit fault);
    for (int i = 0; i < N; i++) begin
      put_vec(i, fault);
      vec_valid = 1'b1;
      cyc();
    end
    vec_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin cyc(); n++; end
    chk("done_reached", done, 1);
  endtask

  task automatic send1(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [3:0] s, input logic co);
    vec_a = a; vec_b = b; vec_cin = c; vec_sum = s; vec_cout = co;
    vec_valid = 1'b1;
    cyc();
  endtask

  initial begin
    int xfers, guard;
    bit x;
    // Reset with valid and start asserted: reset must win.
    rst = 1'b1; vec_valid = 1'b1; start = 1'b1;
    cyc(); cyc();
    rst = 1'b0; start = 1'b0; vec_valid = 1'b0;
    chk("rst_ready", vec_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_vec_cnt", vec_cnt, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_fail", fail_cnt, 0);
    $display("reset: ready=%0b busy=%0b done=%0b", vec_ready, busy, done);

    // Wraparound example: F+1+1 -> sum 1, cout 1.
    do_start();
    send1(4'hF, 4'h1, 1'b1, 4'h1, 1'b1);
    vec_valid = 1'b0;
    cyc();
    chk("wrap_pass", pass_cnt, 1);
    chk("wrap_fail", fail_cnt, 0);
    $display("wrap example: pass=%0d fail=%0d", pass_cnt, fail_cnt);
    rst = 1'b1; cyc(); rst = 1'b0;

    // Exhaustive clean sweep with done latency pinned.
    do_start();
    sweep(1'b0);
    chk("done_t0", done, 0);
    cyc();
    chk("done_t1", done, 0);
    cyc();
    chk("done_t2", done, 1);
    chk("sweep_vec", vec_cnt, 512);
    chk("sweep_pass", pass_cnt, 512);
    chk("sweep_fail", fail_cnt, 0);
    chk("sweep_err", error, 0);
    $display("clean sweep: vec=%0d pass=%0d fail=%0d err=%0b", vec_cnt, pass_cnt, fail_cnt, error);

    // Fault injection: sum bit 0 stuck low.
    do_start();
    sweep(1'b1);
    wait_done();
    chk("fault_pass", pass_cnt, 256);
    chk("fault_fail", fail_cnt, 256);
    chk("fault_err", error, 1);
    $display("fault sweep: pass=%0d fail=%0d err=%0b", pass_cnt, fail_cnt, error);

    // Overrun: valid held for 600 cycles.
    do_start();
    for (int k = 0; k < 600; k++) begin
      put_vec(k % N, 1'b0);
      vec_valid = 1'b1;
      cyc();
    end
    vec_valid = 1'b0;
    chk("ovr_ready", vec_ready, 0);
    chk("ovr_vec", vec_cnt, 512);
    chk("ovr_pass", pass_cnt, 512);
    chk("ovr_done", done, 1);
    $display("overrun: vec=%0d pass=%0d ready=%0b", vec_cnt, pass_cnt, vec_ready);

    // Random valid toggling.
    do_start();
    xfers = 0; guard = 0;
    while (xfers < N && guard < 4000) begin
      put_vec(xfers, 1'b0);
      vec_valid = 1'($urandom_range(0, 1));
      x = vec_valid && vec_ready;
      cyc();
      if (x) xfers++;
      guard++;
    end
    vec_valid = 1'b0;
    chk("toggle_bound", xfers, N);
    wait_done();
    chk("toggle_vec", vec_cnt, 512);
    chk("toggle_pass", pass_cnt, 512);
    chk("toggle_fail", fail_cnt, 0);
    $display("toggled: vec=%0d pass=%0d cycles=%0d", vec_cnt, pass_cnt, guard);

    // Reset mid-run then a full clean sweep.
    do_start();
    for (int i = 0; i < 100; i++) begin
      put_vec(i, 1'b1);
      vec_valid = 1'b1;
      cyc();
    end
    vec_valid = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_vec", vec_cnt, 0);
    chk("mid_fail", fail_cnt, 0);
    do_start();
    sweep(1'b0);
    wait_done();
    chk("mid_pass", pass_cnt, 512);
    $display("mid-run reset: pass=%0d fail=%0d", pass_cnt, fail_cnt);

    // First-failure record.
    do_start();
    send1(4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    send1(4'd1, 4'd1, 1'b1, 4'd0, 1'b0);
    send1(4'd2, 4'd2, 1'b0, 4'd0, 1'b0);
    vec_valid = 1'b0;
    cyc(); cyc();
    chk("ff_fail_cnt", fail_cnt, 2);
    chk("ff_pass_cnt", pass_cnt, 1);
`ifdef CHK_FIRST_FAIL_EN
    chk("ff_valid", ff_valid, 1);
    chk("ff_index", ff_index, 1);
    chk("ff_a", ff_a, 1);
    chk("ff_b", ff_b, 1);
    chk("ff_cin", ff_cin, 1);
    chk("ff_sum", ff_sum, 0);
    chk("ff_cout", ff_cout, 0);
    chk("ff_exp", ff_exp, 5'h03);
    $display("first fail: idx=%0d exp=%0h", ff_index, ff_exp);
`endif
    $display("first-fail run: fail=%0d pass=%0d", fail_cnt, pass_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
